// File: rtl/vcm_i2c_pkg.sv
// Shared types and constants for the VCM I2C writer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vcm_i2c_pkg;

  typedef enum logic [2:0] {IDLE, START, BIT, ACK, STOP} state_t;

  localparam logic [1:0]  Q_LAST   = 2'd3;
  localparam int unsigned N_BYTES  = 3;
  localparam logic        RW_WRITE = 1'b0;

  // Byte on the wire for a given byte index: address+W, then word MSB, then LSB.
  function automatic logic [7:0] tx_byte(input logic [1:0]  idx,
                                         input logic [6:0]  addr,
                                         input logic [15:0] word);
    logic [7:0] b;
    case (idx)
      2'd0:    b = {addr, RW_WRITE};
      2'd1:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/vcm_i2c_writer_qtick.sv
// Quarter-period tick generator: one TICK every CLK_DIV cycles while EN is high.
// Latency: first TICK in the CLK_DIV-th enabled cycle; counter clears whenever EN drops.
// Backpressure: none; EN is the only control.
module i2c_qtick #(
  parameter int unsigned CLK_DIV = 125
) (
  input  logic CLK,
  input  logic RESET,
  input  logic EN,
  output logic TICK
);

  localparam int unsigned   CW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;

  // Free-running divider, held at zero while disabled so every transfer starts phase-aligned.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q <= '0;
    end else if (!EN || (cnt_q == CNT_MAX)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign TICK = EN && (cnt_q == CNT_MAX);

endmodule

// File: rtl/vcm_i2c_writer.sv
// Sends a 16-bit VCM word as one I2C write (START, addr+W, MSB, LSB, STOP) when it changed.
// Latency: 116*CLK_DIV cycles from first BUSY cycle to DONE (44*CLK_DIV on address NACK).
// Backpressure: TRIG while BUSY is remembered once and replayed the cycle after DONE.
module vcm_i2c_writer
  import vcm_i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 125,
  parameter logic [6:0]  SLAVE_ADDR = 7'h0C
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] VCM_DATA,
  input  logic        TRIG,
  input  logic        SDA_IN,
  output logic        SCL,
  output logic        SDA_OE,
  output logic        BUSY,
  output logic        DONE,
  output logic        ACK_ERR,
  output logic [15:0] LAST_SENT
);

  localparam logic [1:0] LAST_BYTE = 2'(N_BYTES - 1);

  state_t      state_q, state_d;
  logic [1:0]  q_q, q_d;
  logic [2:0]  bit_q, bit_d;
  logic [1:0]  byte_q, byte_d;
  logic [15:0] sh_q, sh_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        ack_err_q, ack_err_d;
  logic [15:0] last_sent_q, last_sent_d;
  logic        valid_q, valid_d;
  logic        pend_q, pend_d;
  logic        scl_q, scl_d;
  logic        sda_oe_q, sda_oe_d;
  logic [7:0]  cur_byte;
  logic        tick;

  i2c_qtick #(.CLK_DIV(CLK_DIV)) u_qtick (
    .CLK  (CLK),
    .RESET(RESET),
    .EN   (busy_q),
    .TICK (tick)
  );

  // Next-state: acceptance/dedup in IDLE, quarter/bit/byte sequencing on ticks, bookkeeping at STOP exit.
  always_comb begin
    state_d     = state_q;
    q_d         = q_q;
    bit_d       = bit_q;
    byte_d      = byte_q;
    sh_d        = sh_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    ack_err_d   = ack_err_q;
    last_sent_d = last_sent_q;
    valid_d     = valid_q;
    pend_d      = pend_q;

    if (busy_q && TRIG) pend_d = 1'b1;

    if (state_q == IDLE) begin
      if (TRIG || pend_q) begin
        pend_d = 1'b0;
        if (!valid_q || (VCM_DATA != last_sent_q)) begin
          sh_d      = VCM_DATA;
          state_d   = START;
          q_d       = '0;
          bit_d     = 3'd7;
          byte_d    = '0;
          busy_d    = 1'b1;
          ack_err_d = 1'b0;
        end
      end
    end else if (tick) begin
      // Slave ACK is sampled at the end of the high-SCL first half of the ACK slot.
      if ((state_q == ACK) && (q_q == 2'd2) && SDA_IN) ack_err_d = 1'b1;

      if (q_q != Q_LAST) begin
        q_d = q_q + 2'd1;
      end else begin
        q_d = '0;
        case (state_q)
          START: begin
            state_d = BIT;
            bit_d   = 3'd7;
            byte_d  = '0;
          end
          BIT: begin
            if (bit_q == 3'd0) state_d = ACK;
            else               bit_d   = bit_q - 3'd1;
          end
          ACK: begin
            if (ack_err_q || (byte_q == LAST_BYTE)) begin
              state_d = STOP;
            end else begin
              state_d = BIT;
              bit_d   = 3'd7;
              byte_d  = byte_q + 2'd1;
            end
          end
          STOP: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            if (!ack_err_q) begin
              last_sent_d = sh_q;
              valid_d     = 1'b1;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // Pin levels for the upcoming (state, quarter) so SCL/SDA_OE come straight from flops.
  always_comb begin
    cur_byte = tx_byte(byte_d, SLAVE_ADDR, sh_d);
    scl_d    = 1'b1;
    sda_oe_d = 1'b0;
    case (state_d)
      START: begin
        scl_d    = (q_d != 2'd3);
        sda_oe_d = q_d[1];
      end
      BIT: begin
        scl_d    = q_d[1];
        sda_oe_d = ~cur_byte[bit_d];
      end
      ACK: begin
        scl_d    = q_d[1];
        sda_oe_d = 1'b0;
      end
      STOP: begin
        scl_d    = (q_d != 2'd0);
        sda_oe_d = ~q_d[1];
      end
      default: begin
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
      end
    endcase
  end

  // FSM and output registers; reset releases the bus immediately without a STOP.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      q_q         <= '0;
      bit_q       <= '0;
      byte_q      <= '0;
      sh_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ack_err_q   <= 1'b0;
      last_sent_q <= '0;
      valid_q     <= 1'b0;
      pend_q      <= 1'b0;
      scl_q       <= 1'b1;
      sda_oe_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      q_q         <= q_d;
      bit_q       <= bit_d;
      byte_q      <= byte_d;
      sh_q        <= sh_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ack_err_q   <= ack_err_d;
      last_sent_q <= last_sent_d;
      valid_q     <= valid_d;
      pend_q      <= pend_d;
      scl_q       <= scl_d;
      sda_oe_q    <= sda_oe_d;
    end
  end

  assign SCL       = scl_q;
  assign SDA_OE    = sda_oe_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign ACK_ERR   = ack_err_q;
  assign LAST_SENT = last_sent_q;

endmodule

// File: tb/tb_vcm_i2c_writer.sv
// Directed bench for vcm_i2c_writer with a bit-level I2C slave model and byte scoreboard.
// Latency: checks DONE timing against the quarter-count formula for CLK_DIV=2.
// Backpressure: exercises TRIG-while-busy collapsing into a single follow-up transfer.
module tb_vcm_i2c_writer;

  localparam int unsigned CLK_DIV = 2;
  localparam logic [6:0]  ADDR    = 7'h0C;
  localparam int          FULL    = 116 * CLK_DIV;
  localparam int          NACKD   = 4 * (1 + 9 + 1) * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trig = 1'b0;
  logic [15:0] vcm = 16'h0000;
  logic        scl, sda_oe, busy, done, ack_err;
  logic [15:0] last_sent;
  logic        slv_drv = 1'b0;
  wire         sda = ~(sda_oe | slv_drv);

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  vcm_i2c_writer #(.CLK_DIV(CLK_DIV), .SLAVE_ADDR(ADDR)) dut (
    .CLK      (clk),
    .RESET    (rst),
    .VCM_DATA (vcm),
    .TRIG     (trig),
    .SDA_IN   (sda),
    .SCL      (scl),
    .SDA_OE   (sda_oe),
    .BUSY     (busy),
    .DONE     (done),
    .ACK_ERR  (ack_err),
    .LAST_SENT(last_sent)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [15:0] d);
    logic [7:0] a;
    a = {ADDR, 1'b0};
    exp_q.push_back(a);
    exp_q.push_back(d[15:8]);
    exp_q.push_back(d[7:0]);
  endtask

  // I2C slave model: detects START/STOP, shifts bits on SCL rise, ACKs on the 9th clock.
  int         start_cnt = 0;
  int         stop_cnt  = 0;
  logic       nack_addr = 1'b0;
  logic       prev_scl = 1'b1, prev_sda = 1'b1;
  int         bitcnt = 0;
  int         byte_idx = 0;
  logic [7:0] rx_sh = 8'h00;
  logic       ack_pend = 1'b0, in_ack = 1'b0, ack_val = 1'b0;

  always @(negedge clk) begin
    logic        s;
    logic [31:0] e;
    s = ~(sda_oe | slv_drv);
    if (rst) begin
      slv_drv  = 1'b0;
      in_ack   = 1'b0;
      ack_pend = 1'b0;
      bitcnt   = 0;
    end else if (prev_scl && scl && prev_sda && !s) begin
      start_cnt++;
      bitcnt   = 0;
      byte_idx = 0;
      ack_pend = 1'b0;
      in_ack   = 1'b0;
    end else if (prev_scl && scl && !prev_sda && s) begin
      stop_cnt++;
    end else if (!prev_scl && scl) begin
      if (!in_ack) begin
        rx_sh = {rx_sh[6:0], s};
        bitcnt++;
        if (bitcnt == 8) begin
          e = (exp_q.size() > 0) ? {24'd0, exp_q.pop_front()} : 32'hDEAD_BEEF;
          chk("rx_byte", {24'd0, rx_sh}, e);
          ack_val  = !(nack_addr && (byte_idx == 0));
          byte_idx++;
          bitcnt   = 0;
          ack_pend = 1'b1;
        end
      end
    end else if (prev_scl && !scl) begin
      if (ack_pend) begin
        slv_drv  = ack_val;
        ack_pend = 1'b0;
        in_ack   = 1'b1;
      end else if (in_ack) begin
        slv_drv = 1'b0;
        in_ack  = 1'b0;
      end
    end
    prev_scl = scl;
    prev_sda = ~(sda_oe | slv_drv);
  end

  // Called at the negedge where TRIG (or a pending request) is presented; returns at the DONE negedge.
  // mode 1 injects extra TRIGs and a data change mid-transfer; mode 2 asserts reset at bit slot 12.
  task automatic xfer(input string tag, input int exp_lat, input int mode);
    int cnt;
    bit hit;
    @(posedge clk);
    @(negedge clk);
    trig = 1'b0;
    chk({tag, "_busy_start"}, busy, 1);
    chk({tag, "_ackerr_clr"}, ack_err, 0);
    cnt = 0;
    hit = 0;
    while (cnt < 1000 && !hit) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      if (mode == 1) begin
        trig = (cnt == 40) || (cnt == 80) || (cnt == 120);
        if (cnt == 60) vcm = 16'h3C0F;
      end
      if (mode == 2 && cnt == 104) begin
        chk({tag, "_pre_scl"}, scl, 0);
        chk({tag, "_pre_oe"}, sda_oe, 1);
        rst = 1'b1;
        #1;
        chk({tag, "_scl"}, scl, 1);
        chk({tag, "_oe"}, sda_oe, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        return;
      end
      if (done) hit = 1;
    end
    trig = 1'b0;
    chk({tag, "_latency"}, cnt, exp_lat);
    chk({tag, "_busy_end"}, busy, 0);
  endtask

  task automatic watch_idle(input string tag, input int n);
    int b, d, l;
    b = 0; d = 0; l = 0;
    repeat (n) begin
      @(negedge clk);
      if (busy) b++;
      if (done) d++;
      if (!scl || sda_oe) l++;
    end
    chk({tag, "_busy_cnt"}, b, 0);
    chk({tag, "_done_cnt"}, d, 0);
    chk({tag, "_bus_act"}, l, 0);
  endtask

  initial begin
    int s0;
    repeat (3) @(negedge clk);
    chk("rst_scl", scl, 1);
    chk("rst_oe", sda_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ackerr", ack_err, 0);
    chk("rst_last", last_sent, 16'h0000);
    rst = 1'b0;
    @(negedge clk);

    // Basic transfer
    vcm = 16'h1A5F; push_exp(vcm); trig = 1'b1;
    xfer("t1", FULL, 0);
    chk("t1_ackerr", ack_err, 0);
    chk("t1_last", last_sent, 16'h1A5F);
    chk("t1_rx_left", exp_q.size(), 0);
    chk("t1_starts", start_cnt, 1);
    chk("t1_stops", stop_cnt, 1);

    // Same word again: suppressed
    trig = 1'b1; @(negedge clk); trig = 1'b0;
    watch_idle("dup", 300);
    chk("dup_starts", start_cnt, 1);

    // Fresh reset, zero word still goes out because nothing has been sent yet
    rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
    chk("t4_last_rst", last_sent, 16'h0000);
    vcm = 16'h0000; push_exp(vcm); trig = 1'b1;
    xfer("t4", FULL, 0);
    chk("t4_rx_left", exp_q.size(), 0);
    chk("t4_ackerr", ack_err, 0);

    // Address NACK then retry of the same word
    nack_addr = 1'b1; s0 = stop_cnt;
    vcm = 16'h1234; exp_q.push_back({ADDR, 1'b0}); trig = 1'b1;
    xfer("nack", NACKD, 0);
    chk("nack_ackerr", ack_err, 1);
    chk("nack_last", last_sent, 16'h0000);
    chk("nack_stop", stop_cnt, s0 + 1);
    chk("nack_rx_left", exp_q.size(), 0);
    nack_addr = 1'b0;
    @(negedge clk);
    push_exp(vcm); trig = 1'b1;
    xfer("retry", FULL, 0);
    chk("retry_ackerr", ack_err, 0);
    chk("retry_last", last_sent, 16'h1234);

    // Triggers while busy collapse into one follow-up transfer with the newer word
    s0 = start_cnt;
    vcm = 16'h5555; push_exp(16'h5555); push_exp(16'h3C0F); trig = 1'b1;
    xfer("pend1", FULL, 1);
    chk("pend1_last", last_sent, 16'h5555);
    xfer("pend2", FULL, 0);
    chk("pend2_last", last_sent, 16'h3C0F);
    watch_idle("pend_after", 300);
    chk("pend_starts", start_cnt, s0 + 2);
    chk("pend_rx_left", exp_q.size(), 0);

    // Reset in the middle of byte 1, then a clean transfer
    vcm = 16'h6C81; exp_q.push_back({ADDR, 1'b0}); trig = 1'b1;
    xfer("mrst", 0, 2);
    repeat (2) @(negedge clk);
    chk("mrst_done_held", done, 0);
    chk("mrst_last", last_sent, 16'h0000);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_rx_left", exp_q.size(), 0);
    push_exp(vcm); trig = 1'b1;
    xfer("post", FULL, 0);
    chk("post_last", last_sent, 16'h6C81);
    chk("post_ackerr", ack_err, 0);
    chk("post_rx_left", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vcm_i2c_writer.md
Name: vcm_i2c_writer

Overview:
- Transmits the 16-bit VCM drive word produced by the autofocus step controller to the external VCM driver IC as a single I2C write: START, address+W, data MSB, data LSB, STOP.
- Sits between the autofocus control logic and the camera-board SCL/SDA pins.
- Sends only when triggered and the word differs from the last successfully sent word, so per-frame triggers do not flood the bus.

Parameters:
- CLK_DIV, 125: CLK cycles per SCL quarter-period. 50 MHz / (4·125) = 100 kHz. Legal range ≥1.
- SLAVE_ADDR, 7'h0C: 7-bit driver address. The transmitted address byte is {SLAVE_ADDR,1'b0} = 8'h18.

Ports:
- CLK  in  1  sole clock.
- RESET  in  1  asynchronous, active-high reset.
- VCM_DATA  in  16  word to send. Byte 1 = [15:8], byte 2 = [7:0].
- TRIG  in  1  one-cycle request pulse, CLK domain (typically the VS rising edge).
- SDA_IN  in  1  sampled SDA pin level.
- SCL  out  1  SCL level; 1 = released/high.
- SDA_OE  out  1  1 = drive SDA low, 0 = release.
- BUSY  out  1  transfer in progress.
- DONE  out  1  one-cycle pulse at end of every transfer, ACKed or not.
- ACK_ERR  out  1  set on any NACK; cleared when the next transfer starts.
- LAST_SENT  out  16  last word fully ACKed.

Behaviour:
- Reset values (async, all immediate): SCL=1, SDA_OE=0, BUSY=0, DONE=0, ACK_ERR=0, LAST_SENT=0, VALID=0 (internal), PEND=0. The divider, state and counters also clear.
- Acceptance:
  - TRIG while IDLE: latch VCM_DATA into shift register SH. BUSY=1 on the next cycle.
  - The latch happens only when VALID=0 or VCM_DATA≠LAST_SENT; otherwise TRIG is ignored (no DONE).
- TRIG while BUSY: set PEND. At the transfer end the block returns to IDLE, then re-evaluates with the current VCM_DATA on the following cycle, as if TRIG had arrived; PEND clears. Multiple TRIGs while busy collapse to one.
- Quarter tick: counter 0..CLK_DIV-1 runs only while BUSY. It produces one tick per CLK_DIV cycles. Each state advances its quarter index q (0..3) on a tick.
- States:
  - IDLE.
  - START: q0–q1 SCL=1 SDA_OE=0; q2 SDA_OE=1 (SDA falls with SCL high); q3 SCL=0.
  - BIT: q0 set SDA_OE=~bit with SCL=0; q1 SCL=0; q2–q3 SCL=1.
  - ACK: same as BIT with SDA_OE=0. SDA_IN is sampled on the tick ending q2.
  - STOP: q0 SCL=0 SDA_OE=1; q1 SCL=1; q2 SDA_OE=0 (SDA rises with SCL high); q3 hold.
- Sequencing:
  - START → 8×BIT (address byte, MSB first) → ACK → 8×BIT (byte 1) → ACK → 8×BIT (byte 2) → ACK → STOP → IDLE.
  - Byte counter 0..2, bit counter 7..0.
- NACK (SDA_IN=1 at sample): set ACK_ERR, go directly to STOP. LAST_SENT and VALID are unchanged.
- Success (third ACK=0): at STOP exit, LAST_SENT←SH and VALID←1.
- End of transfer: DONE pulses in the cycle BUSY goes 0.
- Latency, full transfer: 116 quarters = 116·CLK_DIV cycles from the first BUSY cycle to the DONE cycle. This is START 4 + 27 slots·4 + STOP 4.
- SDA_OE changes only while SCL=0, except the START/STOP edges.
- No clock stretching and no arbitration: SCL is driven push-pull-high by level.
- RESET mid-transfer: outputs snap to idle immediately and the bus is released without a STOP. The driver recovers on the next START.
- VCM_DATA changes during a transfer do not affect SH.

Decomposition:
- Package vcm_i2c_pkg:
  - state enum {IDLE, START, BIT, ACK, STOP};
  - Q_LAST = 2'd3;
  - N_BYTES = 3;
  - RW_WRITE = 1'b0.
- One sub-module is natural: i2c_qtick. It holds the CLK_DIV counter, with inputs CLK, RESET, EN and output TICK. The FSM, shifter and bookkeeping stay in the top module.

Test Plan:
- CLK_DIV=2, I2C slave model ACKs all. VCM_DATA=16'h1A5F, TRIG → 116·2=232 cycles later DONE=1. Slave sees bytes 18,1A,5F with START/STOP. LAST_SENT=1A5F, ACK_ERR=0.
- Same word, second TRIG after DONE → no BUSY, no DONE, bus idle.
- After reset, VCM_DATA=16'h0000, TRIG → transfer occurs (VALID=0). Slave receives 18,00,00.
- Slave NACKs the address → ACK_ERR=1 after slot 9, then STOP. DONE occurs at 4·(1+9+1)·CLK_DIV = 88 cycles. LAST_SENT unchanged. Next TRIG with the same word retries.
- Three TRIGs during a transfer, VCM_DATA changed to 16'h3C0F mid-transfer → first transfer sends the old word. Exactly one further transfer sends 3C0F, starting the cycle after the first DONE.
- RESET asserted at bit 12 → same-cycle SCL=1, SDA_OE=0, BUSY=0, no DONE. Next TRIG performs a clean full transfer.
